// File: rtl/pipelined_mult_add_pkg.sv
// Shared constants and types for the pipelined multiply-add unit (y = a*b*c + d).
package pipelined_mult_add_pkg;

    localparam int LATENCY = 3;

    typedef logic [LATENCY-1:0] stage_vld_t;

    function automatic int out_width(input int w);
        return 3 * w;
    endfunction

endpackage

// File: rtl/pipelined_mult_add_pma_stage.sv
// Enable-gated pipeline register with a valid flag; data only loads when valid,
// so idle stages keep their last payload and do not toggle.
module pma_stage
    import pipelined_mult_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (en_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipelined_mult_add.sv
// Three-stage multiply-add y = a*b*c + d with valid/ready on both sides.
// Optional statistics ports are built when PIPELINED_MULT_ADD_STATS_EN is defined.
module pipelined_mult_add
    import pipelined_mult_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OUT_W = out_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             busy
`ifdef PIPELINED_MULT_ADD_STATS_EN
    ,
    output logic [15:0]      result_count,
    output logic             stall_seen
`endif
);

    localparam int PW = 4 * WIDTH;

    function automatic logic [OUT_W-1:0] zext_out(input logic [WIDTH-1:0] v);
        return {{(OUT_W - WIDTH){1'b0}}, v};
    endfunction

    logic             en;
    stage_vld_t       vld;

    logic             vld_p1;
    logic             vld_p2;
    logic             vld_p3;

    logic [2*WIDTH-1:0] ab_d;
    logic [PW-1:0]      s1_d;
    logic [PW-1:0]      s1_p1;
    logic [2*WIDTH-1:0] ab_p1;
    logic [WIDTH-1:0]   c_p1;
    logic [WIDTH-1:0]   d_p1;

    logic [OUT_W-1:0]   abc_d;
    logic [PW-1:0]      s2_d;
    logic [PW-1:0]      s2_p2;
    logic [OUT_W-1:0]   abc_p2;
    logic [WIDTH-1:0]   d_p2;

    logic [OUT_W-1:0]   y_d;
    logic [OUT_W-1:0]   y_p3;

    // The whole pipe advances together; a full output register with no taker stalls everything.
    assign en       = !vld_p3 | out_ready;
    assign in_ready = en;

    // ---- stage 1: a*b, carry c and d ----
    assign ab_d = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign s1_d = {ab_d, c, d};

    pma_stage #(.W(PW)) u_stage1 (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (en),
        .vld_i  (in_valid),
        .data_i (s1_d),
        .vld_o  (vld_p1),
        .data_o (s1_p1)
    );

    assign {ab_p1, c_p1, d_p1} = s1_p1;

    // ---- stage 2: (a*b)*c, carry d ----
    assign abc_d = {{WIDTH{1'b0}}, ab_p1} * {{(2*WIDTH){1'b0}}, c_p1};
    assign s2_d  = {abc_d, d_p1};

    pma_stage #(.W(PW)) u_stage2 (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (en),
        .vld_i  (vld_p1),
        .data_i (s2_d),
        .vld_o  (vld_p2),
        .data_o (s2_p2)
    );

    assign {abc_p2, d_p2} = s2_p2;

    // ---- stage 3: add d; the sum always fits in OUT_W bits ----
    assign y_d = abc_p2 + zext_out(d_p2);

    pma_stage #(.W(OUT_W)) u_stage3 (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (en),
        .vld_i  (vld_p2),
        .data_i (y_d),
        .vld_o  (vld_p3),
        .data_o (y_p3)
    );

    assign vld       = {vld_p3, vld_p2, vld_p1};
    assign busy      = |vld;
    assign out_valid = vld_p3;
    assign y         = y_p3;

`ifdef PIPELINED_MULT_ADD_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        stall_q;
    logic        stall_d;

    always_comb begin
        cnt_d   = cnt_q;
        stall_d = stall_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (out_valid && !out_ready) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 16'd0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign result_count = cnt_q;
    assign stall_seen   = stall_q;
`endif

endmodule
